dmem_arbiter: RTL

//   Shares the single data_memory port between two masters: the CPU load/store port and a debug/loader port.

---
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data_memory port: CPU has fixed priority,
// a starvation counter forces debug grants, and a debug lock holds the port for bursts.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1),
    parameter int OP_W     = 3
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              cpu_req,
    input  logic              cpu_wr_en,
    input  logic [OP_W-1:0]   cpu_mem_op,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_wr_en,
    input  logic [OP_W-1:0]   dbg_mem_op,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              mem_wr_en,
    output logic [OP_W-1:0]   mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic {
        LK_OPEN,
        LK_HELD
    } lock_t;

    lock_t             lock_state;
    logic              locked;
    logic              lock_hold;
    logic              starved;
    logic [WAIT_W-1:0] wait_cnt;
    logic              rpend;
    logic              rsel;
    logic              cpu_rd_gnt;
    logic              dbg_rd_gnt;

    assign locked     = (lock_state == LK_HELD);
    // The lock is honoured only while dbg_lock is still asserted.
    assign lock_hold  = locked & dbg_lock;
    assign starved    = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign cpu_rd_gnt = cpu_gnt & ~cpu_wr_en;
    assign dbg_rd_gnt = dbg_gnt & ~dbg_wr_en;

    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (resetn) begin
            if (lock_hold) begin
                dbg_gnt = dbg_req;
            end else if (cpu_req && dbg_req) begin
                if (starved) dbg_gnt = 1'b1;
                else         cpu_gnt = 1'b1;
            end else begin
                cpu_gnt = cpu_req;
                dbg_gnt = dbg_req;
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        mem_wr_en   = 1'b0;
        mem_op      = cpu_mem_op;
        mem_addr    = '0;
        mem_data_in = '0;
        if (cpu_gnt) begin
            mem_wr_en   = cpu_wr_en;
            mem_addr    = cpu_addr;
            mem_data_in = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_wr_en   = dbg_wr_en;
            mem_op      = dbg_mem_op;
            mem_addr    = dbg_addr;
            mem_data_in = dbg_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_state <= LK_OPEN;
        end else begin
            case (lock_state)
                LK_OPEN: if (dbg_gnt && dbg_lock) lock_state <= LK_HELD;
                LK_HELD: if (!dbg_lock)           lock_state <= LK_OPEN;
                default:                          lock_state <= LK_OPEN;
            endcase
        end
    end

    // Counts consecutive lost cycles of a pending debug request; frozen while locked.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (!locked) begin
            if (dbg_req && !dbg_gnt) begin
                if (!starved) wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rpend     <= 1'b0;
            rsel      <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            rpend <= cpu_rd_gnt | dbg_rd_gnt;
            rsel  <= dbg_rd_gnt;
            if (cpu_rd_gnt) cpu_rdata <= mem_data_out;
            if (dbg_rd_gnt) dbg_rdata <= mem_data_out;
        end
    end

    assign cpu_rvalid = rpend & ~rsel;
    assign dbg_rvalid = rpend & rsel;

    a_one_grant: assert property (@(posedge clk) disable iff (!resetn) !(cpu_gnt && dbg_gnt));

endmodule
